// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch (fixed priority) vs CPU byte bus over one 8192x32 RAM.
// Optional stall statistics counter enabled by defining VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int RAM_AW = 13
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [RAM_AW-1:0] vid_addr,
  output logic [31:0]       vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [14:0]       cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic [RAM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_q,
  output logic [15:0]       stat_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VID_D = 2'd1,
    CPU_D = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              vid_pend;
  logic [RAM_AW-1:0] vid_addr_q;
  logic              cpu_we_q;
  logic [7:0]        cpu_din_q;
  logic [1:0]        cpu_plane_q;
  logic              vid_issue;
  logic              cpu_issue;
  logic [7:0]        cpu_lane;

  // A strobe arriving in IDLE also holds the CPU off, so a coincident
  // video request is served first rather than queued behind the CPU.
  always_comb begin
    state_nxt = state;
    vid_issue = 1'b0;
    cpu_issue = 1'b0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = {4{cpu_din_q}};
    case (state)
      IDLE: begin
        if (vid_pend) begin
          vid_issue = 1'b1;
          mem_addr  = vid_addr_q;
          mem_re    = 1'b1;
          state_nxt = VID_D;
        end else if (cpu_req && !cpu_ack && !vid_req) begin
          cpu_issue = 1'b1;
          mem_addr  = cpu_addr[RAM_AW-1:0];
          mem_re    = !cpu_we;
          mem_we    = cpu_we;
          mem_be    = cpu_we ? (4'b1000 >> cpu_addr[14:13]) : 4'b0000;
          mem_wdata = {4{cpu_din}};
          state_nxt = CPU_D;
        end
      end
      VID_D:   state_nxt = IDLE;
      CPU_D:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Plane 0 lives in the top byte of the word.
  always_comb begin
    case (cpu_plane_q)
      2'd0:    cpu_lane = mem_q[31:24];
      2'd1:    cpu_lane = mem_q[23:16];
      2'd2:    cpu_lane = mem_q[15:8];
      default: cpu_lane = mem_q[7:0];
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      vid_pend    <= 1'b0;
      vid_addr_q  <= '0;
      vid_overrun <= 1'b0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_din_q   <= '0;
      cpu_plane_q <= '0;
      cpu_dout    <= '0;
      cpu_ack     <= 1'b0;
    end else begin
      state     <= state_nxt;
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;

      if (vid_req) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr;
        if (vid_pend)
          vid_overrun <= 1'b1;
      end else if (vid_issue) begin
        vid_pend <= 1'b0;
      end

      if (cpu_issue) begin
        cpu_we_q    <= cpu_we;
        cpu_din_q   <= cpu_din;
        cpu_plane_q <= cpu_addr[14:13];
      end

      if (state == VID_D) begin
        vid_data  <= mem_q;
        vid_valid <= 1'b1;
      end

      if (state == CPU_D) begin
        if (!cpu_we_q)
          cpu_dout <= cpu_lane;
        cpu_ack <= 1'b1;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset)
      stall_cnt <= '0;
    else if (vid_issue && cpu_req && !cpu_ack && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign stat_stall = stall_cnt;
`else
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed vectors push expectations, monitors pop and compare.
module tb_vram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [12:0] vid_addr = '0;
  logic [31:0] vid_data;
  logic        vid_valid;
  logic        vid_overrun;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [12:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_q = '0;
  logic [15:0] stat_stall;

  vram_arbiter #(.RAM_AW(13)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_q(mem_q), .stat_stall(stat_stall)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Behavioural synchronous RAM
  logic [31:0] ram [0:8191];
  always @(posedge clk_sys) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_re) mem_q <= ram[mem_addr];
  end

  typedef struct {int cyc; logic re; logic we; logic [12:0] addr; logic [3:0] be; logic [31:0] wd;} mexp_t;
  typedef struct {int cyc; logic [31:0] d;} vexp_t;
  typedef struct {int cyc; logic rd; logic [7:0] d;} cexp_t;

  mexp_t mq[$];
  vexp_t vq[$];
  cexp_t cq[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors
  always @(negedge clk_sys) begin
    if (mem_re || mem_we) begin
      if (mq.size() == 0) begin
        chk("mem_unexpected_access", {mem_re, mem_we, 17'd0, mem_addr}, 32'd0);
      end else begin
        mexp_t e;
        e = mq.pop_front();
        chk("mem_cycle", cyc, e.cyc);
        chk("mem_re", mem_re, e.re);
        chk("mem_we", mem_we, e.we);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_be", mem_be, e.be);
        if (e.we) chk("mem_wdata", mem_wdata, e.wd);
      end
    end
    if (vid_valid) begin
      if (vq.size() == 0) begin
        chk("vid_unexpected_valid", vid_data, 32'd0);
        n_err += (vid_data == 32'd0) ? 1 : 0;
      end else begin
        vexp_t e;
        e = vq.pop_front();
        chk("vid_cycle", cyc, e.cyc);
        chk("vid_data", vid_data, e.d);
      end
    end
    if (cpu_ack) begin
      if (cq.size() == 0) begin
        chk("cpu_unexpected_ack", cpu_ack, 1'b0);
      end else begin
        cexp_t e;
        e = cq.pop_front();
        chk("cpu_ack_cycle", cyc, e.cyc);
        if (e.rd) chk("cpu_dout", cpu_dout, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_start(input logic we, input logic [14:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
  endtask

  task automatic cpu_finish();
    int n;
    n = 0;
    while (!cpu_ack && n < 20) begin
      tick();
      n++;
    end
    if (!cpu_ack) chk("cpu_ack_timeout", 32'd0, 32'd1);
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic mexp(input int c, input logic we, input logic [12:0] a, input logic [3:0] be, input logic [31:0] wd);
    mq.push_back('{c, !we, we, a, be, wd});
  endtask

  initial begin
    int c;
    for (int i = 0; i < 8192; i++) ram[i] = 32'd0;
    ram[13'h1ABC] = 32'hDEADBEEF;
    ram[13'h0001] = 32'h11223344;
    ram[13'h0002] = 32'hA1B2C3D4;
    ram[13'h0100] = 32'hCAFEF00D;
    ram[13'h0010] = 32'h10101010;
    ram[13'h0020] = 32'h20202020;
    ram[13'h0003] = 32'h33333333;

    idle(3);
    @(negedge clk_sys);
    chk("rst_vid_data", vid_data, 32'd0);
    chk("rst_vid_valid", vid_valid, 32'd0);
    chk("rst_vid_overrun", vid_overrun, 32'd0);
    chk("rst_cpu_dout", cpu_dout, 32'd0);
    chk("rst_cpu_ack", cpu_ack, 32'd0);
    chk("rst_stat_stall", stat_stall, 32'd0);
    chk("rst_mem_re", mem_re, 32'd0);
    chk("rst_mem_we", mem_we, 32'd0);
    chk("rst_mem_be", mem_be, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    tick();
    reset = 1'b0;
    idle(2);

    // Video fetch on an idle bus
    c = cyc;
    vid_req = 1'b1; vid_addr = 13'h1ABC;
    mexp(c + 1, 1'b0, 13'h1ABC, 4'b0000, 32'd0);
    vq.push_back('{c + 3, 32'hDEADBEEF});
    tick();
    vid_req = 1'b0;
    idle(5);

    // CPU write to plane 2, word 5
    c = cyc;
    cpu_start(1'b1, 15'h4005, 8'h5A);
    mexp(c, 1'b1, 13'h0005, 4'b0010, 32'h5A5A5A5A);
    cq.push_back('{c + 2, 1'b0, 8'h00});
    cpu_finish();
    idle(2);

    // Read it back through the same plane
    c = cyc;
    cpu_start(1'b0, 15'h4005, 8'h00);
    mexp(c, 1'b0, 13'h0005, 4'b0000, 32'd0);
    cq.push_back('{c + 2, 1'b1, 8'h5A});
    cpu_finish();
    idle(2);

    // CPU read of plane 3, word 1
    c = cyc;
    cpu_start(1'b0, 15'h6001, 8'h00);
    mexp(c, 1'b0, 13'h0001, 4'b0000, 32'd0);
    cq.push_back('{c + 2, 1'b1, 8'h44});
    cpu_finish();
    idle(2);

    // Coincident video and CPU read: video first
    c = cyc;
    vid_req = 1'b1; vid_addr = 13'h0100;
    cpu_start(1'b0, 15'h2002, 8'h00);
    mexp(c + 1, 1'b0, 13'h0100, 4'b0000, 32'd0);
    mexp(c + 3, 1'b0, 13'h0002, 4'b0000, 32'd0);
    vq.push_back('{c + 3, 32'hCAFEF00D});
    cq.push_back('{c + 5, 1'b1, 8'hB2});
    tick();
    vid_req = 1'b0;
    cpu_finish();
    idle(2);
`ifdef VRAM_ARB_STATS_EN
    chk("stat_stall_after_contention", stat_stall, 32'd1);
`else
    chk("stat_stall_disabled", stat_stall, 32'd0);
`endif
    chk("overrun_before", vid_overrun, 32'd0);

    // Back-to-back strobes: second overwrites the pending address
    c = cyc;
    vid_req = 1'b1; vid_addr = 13'h0010;
    mexp(c + 1, 1'b0, 13'h0010, 4'b0000, 32'd0);
    mexp(c + 3, 1'b0, 13'h0020, 4'b0000, 32'd0);
    vq.push_back('{c + 3, 32'h10101010});
    vq.push_back('{c + 5, 32'h20202020});
    tick();
    vid_addr = 13'h0020;
    tick();
    vid_req = 1'b0;
    idle(5);
    chk("overrun_sticky", vid_overrun, 32'd1);

    // Reset while in CPU_D, with a video strobe in the same cycle
    c = cyc;
    cpu_start(1'b0, 15'h0003, 8'h00);
    mexp(c, 1'b0, 13'h0003, 4'b0000, 32'd0);
    tick();
    reset = 1'b1; cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 13'h0030;
    tick();
    reset = 1'b0; vid_req = 1'b0;
    @(negedge clk_sys);
    chk("rst_mid_cpu_ack", cpu_ack, 32'd0);
    chk("rst_mid_vid_valid", vid_valid, 32'd0);
    chk("rst_mid_mem_re", mem_re, 32'd0);
    chk("rst_mid_overrun", vid_overrun, 32'd0);
    idle(8);
    chk("rst_mid_stat_stall", stat_stall, 32'd0);

    chk("mem_queue_drained", mq.size(), 32'd0);
    chk("vid_queue_drained", vq.size(), 32'd0);
    chk("cpu_queue_drained", cq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
